// File: rtl/proc_op_sequencer_pkg.sv
// Shared definitions for the command-driven process sequencer:
// op codes, FSM state encoding and the queued command word layout.
package proc_seq_pkg;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_CPL  = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_SHL  = 2'b11;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_ITER   = 2'd2;
  localparam logic [1:0] S_RESULT = 2'd3;

  typedef struct packed {
    logic [3:0] data;
    logic [1:0] op;
    logic [1:0] sh;
    logic [1:0] rpt;
  } cmd_word_t;

  localparam int CMD_W = $bits(cmd_word_t);

  function automatic cmd_word_t pack_cmd(input logic [3:0] data, input logic [1:0] op,
                                         input logic [1:0] sh, input logic [1:0] rpt);
    cmd_word_t w;
    w.data = data;
    w.op   = op;
    w.sh   = sh;
    w.rpt  = rpt;
    return w;
  endfunction

endpackage

// File: rtl/proc_op_sequencer_if.sv
// Command and result handshake bundle between a command source/result consumer
// (master) and the sequencer (slave).
interface proc_op_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_data;
  logic [1:0] cmd_op;
  logic [1:0] cmd_sh;
  logic [1:0] cmd_rpt;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;

  modport master (
    output cmd_valid, cmd_data, cmd_op, cmd_sh, cmd_rpt, res_ready,
    input  cmd_ready, res_valid, res_data
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_op, cmd_sh, cmd_rpt, res_ready,
    output cmd_ready, res_valid, res_data
  );
endinterface

// File: rtl/proc_op_sequencer_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit so that
// full/empty/count fall out of a single subtraction.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/proc_op_sequencer.sv
// Command-driven sequencer for the 4-bit register + process datapath: queues
// commands, runs each op repeat+1 times through the datapath, returns the result.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for a queued command; pops the FIFO head when present
// S_LOAD   | datapath register loads the command operand
// S_ITER   | datapath register recirculates dp_out, once per extra pass
// S_RESULT | register held, dp_out presented as res_data until accepted
module proc_op_sequencer
  import proc_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  proc_op_sequencer_if.slave  bus,
  output logic                dp_load,
  output logic                dp_rg,
  output logic [3:0]          dp_in,
  output logic [1:0]          dp_ch,
  output logic [1:0]          dp_sh,
  input  logic [3:0]          dp_out,
  output logic                busy
);

  logic [1:0]              state;
  cmd_word_t               cur;
  logic [1:0]              cnt;

  cmd_word_t               fifo_head;
  logic [CMD_W-1:0]        fifo_rdata;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_count_unused;

  assign fifo_push         = bus.cmd_valid && !fifo_full;
  assign fifo_pop          = (state == S_IDLE) && !fifo_empty;
  assign fifo_head         = cmd_word_t'(fifo_rdata);
  assign fifo_count_unused = ^fifo_count;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_cmd_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (pack_cmd(bus.cmd_data, bus.cmd_op, bus.cmd_sh, bus.cmd_rpt)),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cur   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            cur   <= fifo_head;
            cnt   <= fifo_head.rpt;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          state <= (cnt != '0) ? S_ITER : S_RESULT;
        end
        S_ITER: begin
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1) state <= S_RESULT;
        end
        S_RESULT: begin
          if (bus.res_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Op select stays on cur_* through RESULT because dp_out is combinational on it.
  assign busy          = (state != S_IDLE);
  assign dp_load       = (state == S_LOAD) || (state == S_ITER);
  assign dp_rg         = (state == S_ITER);
  assign dp_in         = (state == S_LOAD) ? cur.data : 4'd0;
  assign dp_ch         = busy ? cur.op : 2'd0;
  assign dp_sh         = busy ? cur.sh : 2'd0;

  assign bus.cmd_ready = !fifo_full;
  assign bus.res_valid = (state == S_RESULT);
  assign bus.res_data  = bus.res_valid ? dp_out : 4'd0;

endmodule

// File: tb/tb_proc_op_sequencer.sv
// Directed bench for proc_op_sequencer with the real register + process datapath
// and a queue-based result model checked every cycle.
module tb_proc_op_sequencer;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       dp_load, dp_rg, busy;
  logic [3:0] dp_in, dp_out;
  logic [1:0] dp_ch, dp_sh;
  logic [3:0] dp_reg;

  int vectors     = 0;
  int miscompares = 0;
  int results     = 0;
  int load_cnt    = 0;
  logic rg_q [$];
  logic [3:0] exp_q [$];

  proc_op_sequencer_if bus();

  proc_op_sequencer #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .dp_load (dp_load),
    .dp_rg   (dp_rg),
    .dp_in   (dp_in),
    .dp_ch   (dp_ch),
    .dp_sh   (dp_sh),
    .dp_out  (dp_out),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] apply_op(input logic [3:0] v, input logic [1:0] op,
                                          input logic [1:0] sh);
    case (op)
      2'b00:   return v;
      2'b01:   return ~v;
      2'b10:   return v >> sh;
      default: return v << sh;
    endcase
  endfunction

  function automatic logic [3:0] expected(input logic [3:0] d, input logic [1:0] op,
                                          input logic [1:0] sh, input logic [1:0] r);
    logic [3:0] v;
    v = d;
    for (int i = 0; i <= int'(r); i++) v = apply_op(v, op, sh);
    return v;
  endfunction

  // Datapath: 4-bit register feeding a combinational process unit.
  always @(posedge clk) if (dp_load) dp_reg <= dp_rg ? dp_out : dp_in;
  assign dp_out = apply_op(dp_reg, dp_ch, dp_sh);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (bus.res_valid) begin
        if (exp_q.size() == 0) check("res_unexpected", 32'(bus.res_valid), 0);
        else begin
          check("res_data", 32'(bus.res_data), 32'(exp_q[0]));
          if (bus.res_ready) begin
            void'(exp_q.pop_front());
            results++;
          end
        end
      end else begin
        check("res_data_idle", 32'(bus.res_data), 0);
      end
      if (bus.cmd_valid && bus.cmd_ready)
        exp_q.push_back(expected(bus.cmd_data, bus.cmd_op, bus.cmd_sh, bus.cmd_rpt));
      if (dp_load) begin
        load_cnt++;
        rg_q.push_back(dp_rg);
      end
    end
  end

  task automatic send(input logic [3:0] d, input logic [1:0] op, input logic [1:0] sh,
                      input logic [1:0] r);
    bit ok;
    ok = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = d;
    bus.cmd_op    = op;
    bus.cmd_sh    = sh;
    bus.cmd_rpt   = r;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      check("send_ready_timeout", 32'(bus.cmd_ready), 1);
      bus.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_res(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.res_valid) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) check("res_timeout", 32'(bus.res_valid), 1);
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int base;
    logic [3:0] d5  [6] = '{4'b1011, 4'b0110, 4'b1111, 4'b0001, 4'b1100, 4'b1010};
    logic [1:0] op5 [6] = '{2'b11,   2'b01,   2'b10,   2'b00,   2'b11,   2'b01};
    logic [1:0] sh5 [6] = '{2'b01,   2'b00,   2'b10,   2'b00,   2'b11,   2'b00};
    logic [1:0] r5  [6] = '{2'd1,    2'd0,    2'd1,    2'd3,    2'd0,    2'd2};

    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.cmd_op    = '0;
    bus.cmd_sh    = '0;
    bus.cmd_rpt   = '0;
    bus.res_ready = 1'b1;

    // 1. reset state and quiet idle
    #12;
    check("t1_res_valid", 32'(bus.res_valid), 0);
    check("t1_dp_load", 32'(dp_load), 0);
    check("t1_busy", 32'(busy), 0);
    check("t1_cmd_ready", 32'(bus.cmd_ready), 1);
    @(posedge clk);
    #1 reset = 1'b0;
    step(5);
    check("t1_idle_loads", 32'(load_cnt), 0);

    // 2. single pass left shift
    load_cnt = 0;
    rg_q.delete();
    send(4'b1011, 2'b11, 2'b01, 2'd0);
    wait_res(lat);
    check("t2_latency", 32'(lat), 2);
    check("t2_data", 32'(bus.res_data), 32'(4'b0110));
    step(1);
    check("t2_loads", 32'(load_cnt), 1);
    if (rg_q.size() > 0) check("t2_rg", 32'(rg_q[0]), 0);

    // 3. complement three times
    load_cnt = 0;
    rg_q.delete();
    send(4'b0101, 2'b01, 2'b00, 2'd2);
    wait_res(lat);
    check("t3_latency", 32'(lat), 4);
    check("t3_data", 32'(bus.res_data), 32'(4'b1010));
    step(1);
    check("t3_loads", 32'(load_cnt), 3);
    if (rg_q.size() == 3) check("t3_rg_seq", 32'({rg_q[0], rg_q[1], rg_q[2]}), 32'(3'b011));

    // 4. right shift recirculated, then pass with max repeat
    send(4'b1000, 2'b10, 2'b01, 2'd2);
    wait_res(lat);
    check("t4a_data", 32'(bus.res_data), 32'(4'b0001));
    step(1);
    send(4'b0110, 2'b00, 2'b00, 2'd3);
    wait_res(lat);
    check("t4b_latency", 32'(lat), 5);
    check("t4b_data", 32'(bus.res_data), 32'(4'b0110));
    step(1);

    // 5. backpressure: one in RESULT, DEPTH queued, sixth refused
    bus.res_ready = 1'b0;
    base = results;
    for (int i = 0; i < 5; i++) send(d5[i], op5[i], sh5[i], r5[i]);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = d5[5];
    bus.cmd_op    = op5[5];
    bus.cmd_sh    = sh5[5];
    bus.cmd_rpt   = r5[5];
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t5_full", 32'(bus.cmd_ready), 0);
    end
    check("t5_busy", 32'(busy), 1);
    check("t5_res_held", 32'(bus.res_valid), 1);
    check("t5_first_data", 32'(bus.res_data), 32'(4'b1100));
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (results - base >= 5) break;
      step(1);
    end
    check("t5_result_count", 32'(results - base), 5);
    step(1);
    check("t5_idle_after", 32'(busy), 0);

    // 6. reset while iterating with two commands queued
    send(4'b1001, 2'b11, 2'b01, 2'd3);
    send(4'b0111, 2'b01, 2'b00, 2'd0);
    send(4'b0010, 2'b10, 2'b01, 2'd1);
    check("t6_in_iter", 32'({dp_load, dp_rg}), 32'(2'b11));
    #2 reset = 1'b1;
    #1;
    check("t6_busy", 32'(busy), 0);
    check("t6_res_valid", 32'(bus.res_valid), 0);
    check("t6_cmd_ready", 32'(bus.cmd_ready), 1);
    check("t6_dp_load", 32'(dp_load), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    load_cnt = 0;
    step(4);
    check("t6_fifo_empty", 32'(load_cnt), 0);
    send(4'b0011, 2'b11, 2'b01, 2'd1);
    wait_res(lat);
    check("t6_latency", 32'(lat), 3);
    check("t6_data", 32'(bus.res_data), 32'(4'b1100));
    step(2);
    check("t6_drained", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
